imem_loader: RTL
================

Name: imem_loader

Overview:
- Write-side companion to the instruction memory: receives a byte stream (UART/debug bridge), assembles little-endian 32-bit words and issues word-aligned writes into instruction memory.
- Holds the CPU in reset while loading.
- Sits between the host byte source and the instruction memory write port, under the top-level load controller.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word-aligned.
- MAX_WORDS, 1024, largest accepted program length in words.
- LEN_W, 16, width of the word_count input.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; sampled only in IDLE.
- word_count  in  LEN_W  program length in words; latched on an accepted start.
- in_valid  in  1  byte-source data valid.
- in_data  in  8  byte from the source.
- in_ready  out  1  loader accepts a byte this cycle; a transfer occurs when in_valid and in_ready are both 1.
- we  out  1  instruction memory write enable, one cycle per word.
- waddr  out  32  byte address of the write; waddr[1:0] is always 2'b00.
- wdata  out  32  assembled word.
- busy  out  1  high in every state except IDLE.
- cpu_rst_hold  out  1  equals busy; holds the core in reset during a load.
- done  out  1  single-cycle pulse when the load ends, whether it succeeded or failed.
- err  out  1  sticky error flag; valid when done is high; cleared on the next accepted start.

Behaviour:
- Reset (synchronous): state=IDLE, in_ready=0, we=0, waddr=BASE_ADDR, wdata=0, busy=0, cpu_rst_hold=0, done=0, err=0. The byte counter and word index are cleared.
- States are IDLE, RECV, WRITE and FIN.
- IDLE:
  - start=1 latches word_count into len and clears err.
  - len==0: go to FIN, no writes.
  - len>MAX_WORDS: set err=1, go to FIN, no writes.
  - Otherwise go to RECV with word_idx=0 and byte_cnt=0.
- RECV:
  - in_ready=1.
  - Each transfer places in_data at wdata[8*byte_cnt +: 8]. The first byte is the least significant.
  - byte_cnt is 2 bits and wraps after 3.
  - On the transfer with byte_cnt==3, go to WRITE.
  - When in_valid=0, the state and the partial word hold indefinitely.
- WRITE:
  - in_ready=0, we=1 for exactly one cycle.
  - waddr=BASE_ADDR+{word_idx,2'b00}; wdata is stable.
  - If word_idx==len-1, go to FIN. Otherwise increment word_idx and go to RECV.
- FIN: done=1 for one cycle, then IDLE. busy falls in the same cycle the state returns to IDLE.
- Latency:
  - The first write occurs 1 cycle after the 4th byte is accepted.
  - Minimum throughput is 5 cycles per word (4 bytes + 1 write cycle).
- start is ignored while busy; no restart or queueing.
- Address arithmetic is modulo 2^32. MAX_WORDS bounds the range, so no wrap occurs in a legal configuration.
- rst asserted mid-load:
  - Immediate return to IDLE; the partial word is discarded.
  - No we is asserted in the reset cycle.
  - No done pulse; words already written remain in memory.
- in_valid arriving outside RECV is not consumed, because in_ready=0.

Optional Feature:
- Macro: IMEM_LOADER_CKSUM_EN.
- With the macro defined:
  - After the last WRITE, the FSM enters a CKSUM state instead of FIN, with in_ready=1.
  - It accepts one extra byte and compares it with the XOR of all program bytes. A running 8-bit register is cleared on start and updated on every RECV transfer.
  - On mismatch, err=1. Then go to FIN.
  - len==0 skips CKSUM.
- Without the macro: there is no CKSUM state and no checksum register; err reflects only the length check.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum (IDLE, RECV, WRITE, CKSUM, FIN);
  - localparam BYTES_PER_WORD=4;
  - localparam IMEM_ADDR_LSB=2.
- One natural sub-module, imem_word_assembler, owns the byte counter, the little-endian shift-in into wdata, and a word_ready strobe.
- The top-level FSM, address generation and checksum stay in imem_loader.

Test Plan:
- Reset, then start with word_count=2 and bytes 13,00,50,00,93,00,10,00 → two writes: (waddr=0x0, wdata=0x00500013) and (waddr=0x4, wdata=0x00100093). done pulses once, err=0, busy and cpu_rst_hold are high throughout.
- word_count=0 → done 2 cycles after start, no we, err=0.
- word_count=1025 with MAX_WORDS=1024 → err=1 with done, no we, in_ready never asserted.
- Load of 3 words with in_valid toggling every other cycle → writes at 0x0, 0x4, 0x8 with correct data; no byte lost or duplicated.
- rst asserted after 6 bytes of a 4-word load → one write at 0x0 only, state IDLE, no done. A new load afterwards writes from BASE_ADDR.
- IMEM_LOADER_CKSUM_EN, 1 word 0xDEADBEEF:
  - checksum byte 0x22 → err=0.
  - checksum byte 0x23 → err=1.
  - The word is written in both cases.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CKSUM,
        FIN
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int IMEM_ADDR_LSB  = 2;

    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [31:0] idx);
        return base + (idx << IMEM_ADDR_LSB);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: control, byte stream (valid/ready) and instruction-memory write port.
// A byte moves on a rising clk edge where in_valid and in_ready are both 1; the
// source keeps in_data stable while in_valid is high and may drop in_valid freely.
interface imem_loader_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] word_count;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             we;
    logic [31:0]      waddr;
    logic [31:0]      wdata;
    logic             busy;
    logic             cpu_rst_hold;
    logic             done;
    logic             err;

    modport master (
        output start, word_count, in_valid, in_data,
        input  in_ready, we, waddr, wdata, busy, cpu_rst_hold, done, err
    );

    modport slave (
        input  start, word_count, in_valid, in_data,
        output in_ready, we, waddr, wdata, busy, cpu_rst_hold, done, err
    );
endinterface

// File: rtl/imem_word_assembler.sv
// Packs a byte stream into little-endian 32-bit words; strobes on the 4th byte.
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        if (clear_i) begin
            byte_cnt_d = 2'd0;
        end else if (push_i) begin
            word_d[8*byte_cnt_q +: 8] = byte_i;
            byte_cnt_d                = byte_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q <= 2'd0;
            word_q     <= 32'd0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
        end
    end

    assign word_o       = word_q;
    assign word_ready_o = push_i && (byte_cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory loader; holds the CPU in reset while loading.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024,
    parameter int          LEN_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    imem_loader_if.slave    bus,
    output state_e          state_o
);
    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] word_idx_q, word_idx_d;
    logic             err_q, err_d;
    logic             start_acc;
    logic             push;
    logic             word_ready;
    logic             in_ready;
    logic             we_raw;
    logic             done;
    logic [31:0]      word;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]       cksum_q, cksum_d;
    localparam state_e LAST_WRITE_NEXT = CKSUM;
`else
    localparam state_e LAST_WRITE_NEXT = FIN;
`endif

    imem_word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (start_acc),
        .push_i       (push),
        .byte_i       (bus.in_data),
        .word_o       (word),
        .word_ready_o (word_ready)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        err_d      = err_q;
        start_acc  = 1'b0;
        push       = 1'b0;
        in_ready   = 1'b0;
        we_raw     = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    start_acc  = 1'b1;
                    len_d      = bus.word_count;
                    err_d      = 1'b0;
                    word_idx_d = '0;
                    if (bus.word_count == '0) begin
                        state_d = FIN;
                    end else if (32'(bus.word_count) > 32'(MAX_WORDS)) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        state_d = RECV;
                    end
                end
            end
            RECV: begin
                in_ready = 1'b1;
                push     = bus.in_valid;
                if (word_ready) state_d = WRITE;
            end
            WRITE: begin
                we_raw = 1'b1;
                if (word_idx_q == len_q - 1'b1) begin
                    state_d = LAST_WRITE_NEXT;
                end else begin
                    word_idx_d = word_idx_q + 1'b1;
                    state_d    = RECV;
                end
            end
`ifdef IMEM_LOADER_CKSUM_EN
            CKSUM: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (bus.in_data != cksum_q) err_d = 1'b1;
                    state_d = FIN;
                end
            end
`endif
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef IMEM_LOADER_CKSUM_EN
    always_comb begin
        cksum_d = cksum_q;
        if (start_acc)  cksum_d = 8'd0;
        else if (push)  cksum_d = cksum_q ^ bus.in_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            err_q      <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum_q    <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            err_q      <= err_d;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum_q    <= cksum_d;
`endif
        end
    end

    // Write enable is gated by rst so a reset landing on a WRITE cycle never commits.
    assign bus.we           = we_raw && !rst;
    assign bus.in_ready     = in_ready;
    assign bus.waddr        = word_addr(BASE_ADDR, 32'(word_idx_q));
    assign bus.wdata        = word;
    assign bus.busy         = (state_q != IDLE);
    assign bus.cpu_rst_hold = (state_q != IDLE);
    assign bus.done         = done;
    assign bus.err          = err_q;
    assign state_o          = state_q;

endmodule
